// File: rtl/pc_fetch_ctrl.sv
// IF-stage program-counter sequencer: owns the PC, issues req/gnt fetches to instruction memory,
// and arbitrates sequential fetch against hazard stalls and EX-stage redirects.
module pc_fetch_ctrl #(
  parameter int unsigned     PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     INC      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            imem_gnt_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  output logic            if_valid_o,
  output logic [PC_W-1:0] if_pc_o,
  output logic            flush_o
);

  typedef enum logic [1:0] {StBoot, StFetch, StBubble} state_e;

  state_e          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic            r_if_valid, w_if_valid_nxt;
  logic [PC_W-1:0] r_if_pc, w_if_pc_nxt;
  logic            r_flush, w_flush_nxt;
  logic            w_req;
  logic [PC_W-1:0] w_redirect_pc;
  logic            w_unused_lsbs;

  // Targets are word aligned; the low address bits from EX are dropped.
  assign w_redirect_pc = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign w_unused_lsbs = ^redirect_pc_i[1:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_flush_nxt    = 1'b0;
    w_req          = 1'b0;

    unique case (r_state)
      StBoot:   w_state_nxt = StFetch;
      StFetch:  w_req = !stall_i && !redirect_valid_i;
      StBubble: w_req = 1'b0;
      default:  w_state_nxt = StBoot;
    endcase

    if (r_state == StFetch || r_state == StBubble) begin
      if (redirect_valid_i) begin
        w_pc_nxt       = w_redirect_pc;
        w_flush_nxt    = 1'b1;
        w_if_valid_nxt = 1'b0;
        w_state_nxt    = StBubble;
      end else if (stall_i) begin
        w_state_nxt = r_state;
      end else if (r_state == StFetch) begin
        if (imem_gnt_i) begin
          w_if_valid_nxt = 1'b1;
          w_if_pc_nxt    = r_pc;
          w_pc_nxt       = r_pc + PC_W'(INC);
        end else begin
          w_if_valid_nxt = 1'b0;
        end
      end else begin
        w_if_valid_nxt = 1'b0;
        w_state_nxt    = StFetch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StBoot;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_flush    <= w_flush_nxt;
    end
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign if_valid_o  = r_if_valid;
  assign if_pc_o     = r_if_pc;
  assign flush_o     = r_flush;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: inputs change 1ns after the rising edge, outputs are
// checked 1ns later, so registered outputs reflect the previous edge.
module tb_pc_fetch_ctrl;
  localparam int unsigned PC_W = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall_i;
  logic            redirect_valid_i;
  logic [PC_W-1:0] redirect_pc_i;
  logic            imem_gnt_i;
  logic            imem_req_o;
  logic [PC_W-1:0] imem_addr_o;
  logic            if_valid_o;
  logic [PC_W-1:0] if_pc_o;
  logic            flush_o;

  int n_chk  = 0;
  int n_fail = 0;
  int n_flush;

  pc_fetch_ctrl #(.PC_W(PC_W), .RESET_PC(10'h000), .INC(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_gnt_i       (imem_gnt_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .if_valid_o       (if_valid_o),
    .if_pc_o          (if_pc_o),
    .flush_o          (flush_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks all five outputs against expected values; name identifies the step.
  task automatic expect_all(input string name, input logic req, input logic [PC_W-1:0] addr,
                            input logic vld, input logic [PC_W-1:0] ipc, input logic fl);
    #1;
    n_chk++;
    if (imem_req_o !== req) begin
      n_fail++; $display("FAIL %s req: got %b want %b", name, imem_req_o, req);
    end
    n_chk++;
    if (imem_addr_o !== addr) begin
      n_fail++; $display("FAIL %s addr: got %h want %h", name, imem_addr_o, addr);
    end
    n_chk++;
    if (if_valid_o !== vld) begin
      n_fail++; $display("FAIL %s if_valid: got %b want %b", name, if_valid_o, vld);
    end
    n_chk++;
    if (if_pc_o !== ipc) begin
      n_fail++; $display("FAIL %s if_pc: got %h want %h", name, if_pc_o, ipc);
    end
    n_chk++;
    if (flush_o !== fl) begin
      n_fail++; $display("FAIL %s flush: got %b want %b", name, flush_o, fl);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; redirect_valid_i = 1'b0;
    redirect_pc_i = '0; imem_gnt_i = 1'b1;
    tick(); tick();
    expect_all("reset", 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
    rst_n = 1'b1;
    expect_all("boot", 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
    tick();
  endtask

  task automatic test_seq_fetch();
    expect_all("seq0", 1'b1, 10'h000, 1'b0, 10'h000, 1'b0);
    tick();
    expect_all("seq1", 1'b1, 10'h004, 1'b1, 10'h000, 1'b0);
    tick();
    expect_all("seq2", 1'b1, 10'h008, 1'b1, 10'h004, 1'b0);
  endtask

  task automatic test_no_grant();
    imem_gnt_i = 1'b0;
    expect_all("nognt0", 1'b1, 10'h008, 1'b1, 10'h004, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_all("nognt_wait", 1'b1, 10'h008, 1'b0, 10'h004, 1'b0);
    end
    imem_gnt_i = 1'b1;
    tick();
    expect_all("nognt_done", 1'b1, 10'h00C, 1'b1, 10'h008, 1'b0);
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    expect_all("stall0", 1'b0, 10'h00C, 1'b1, 10'h008, 1'b0);
    tick();
    expect_all("stall1", 1'b0, 10'h00C, 1'b1, 10'h008, 1'b0);
    tick();
    stall_i = 1'b0;
    expect_all("stall_rel", 1'b1, 10'h00C, 1'b1, 10'h008, 1'b0);
    tick();
    expect_all("stall_resume", 1'b1, 10'h010, 1'b1, 10'h00C, 1'b0);
  endtask

  task automatic test_redirect();
    redirect_valid_i = 1'b1; redirect_pc_i = 10'h1A7;
    expect_all("redir_req", 1'b0, 10'h010, 1'b1, 10'h00C, 1'b0);
    tick();
    redirect_valid_i = 1'b0;
    expect_all("redir_bubble", 1'b0, 10'h1A4, 1'b0, 10'h00C, 1'b1);
    tick();
    expect_all("redir_fetch", 1'b1, 10'h1A4, 1'b0, 10'h00C, 1'b0);
    tick();
    expect_all("redir_next", 1'b1, 10'h1A8, 1'b1, 10'h1A4, 1'b0);
  endtask

  task automatic test_redirect_stall_bubble();
    n_flush = 0;
    redirect_valid_i = 1'b1; redirect_pc_i = 10'h0F0; stall_i = 1'b1;
    expect_all("rs_req", 1'b0, 10'h1A8, 1'b1, 10'h1A4, 1'b0);
    tick();
    if (flush_o === 1'b1) n_flush++;
    redirect_pc_i = 10'h200; stall_i = 1'b0;
    expect_all("rs_bubble", 1'b0, 10'h0F0, 1'b0, 10'h1A4, 1'b1);
    tick();
    if (flush_o === 1'b1) n_flush++;
    redirect_valid_i = 1'b0;
    expect_all("rs_bubble2", 1'b0, 10'h200, 1'b0, 10'h1A4, 1'b1);
    tick();
    if (flush_o === 1'b1) n_flush++;
    expect_all("rs_fetch", 1'b1, 10'h200, 1'b0, 10'h1A4, 1'b0);
    n_chk++;
    if (n_flush !== 2) begin
      n_fail++; $display("FAIL rs_flush_count: got %0d want 2", n_flush);
    end
    tick();
    expect_all("rs_next", 1'b1, 10'h204, 1'b1, 10'h200, 1'b0);
  endtask

  task automatic test_wrap_and_reset();
    redirect_valid_i = 1'b1; redirect_pc_i = 10'h3FE;
    tick();
    redirect_valid_i = 1'b0;
    tick();
    expect_all("wrap0", 1'b1, 10'h3FC, 1'b0, 10'h200, 1'b0);
    tick();
    expect_all("wrap1", 1'b1, 10'h000, 1'b1, 10'h3FC, 1'b0);
    tick();
    expect_all("wrap2", 1'b1, 10'h004, 1'b1, 10'h000, 1'b0);
    tick();
    expect_all("pre_rst", 1'b1, 10'h008, 1'b1, 10'h004, 1'b0);
    rst_n = 1'b0;
    expect_all("mid_rst", 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
    tick();
    rst_n = 1'b1;
    expect_all("reboot", 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
    tick();
    expect_all("reboot_fetch", 1'b1, 10'h000, 1'b0, 10'h000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_no_grant();
    test_stall();
    test_redirect();
    test_redirect_stall_bubble();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
